// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_engine
// Description : WIDTH-bit LED pattern generator. A debounced push-button
//               cycles through CHASE, BOUNCE, TOGGLE and COUNT patterns. A
//               free-running step timer advances the active pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_engine #(
  parameter int WIDTH       = 8,
  parameter int STEP_CYCLES = 1000000,
  parameter int DB_CYCLES   = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_button,
  input  logic             dir,
  output logic [WIDTH-1:0] led_out,
  output logic [1:0]       mode_out,
  output logic             step_pulse
);

  localparam int c_STEP_W = $clog2(STEP_CYCLES);
  localparam int c_DB_W   = $clog2(DB_CYCLES + 1);

  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CYCLES - 1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
  localparam logic [WIDTH-1:0]    c_ONE       = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_CHASE  = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_TOGGLE = 2'd2,
    ST_COUNT  = 2'd3
  } mode_t;

  logic                r_s1;
  logic                r_s2;
  logic                r_db_level;
  logic [c_DB_W-1:0]   r_db_cnt;
  logic [c_STEP_W-1:0] r_step_cnt;
  mode_t               r_mode;
  mode_t               w_mode_next;
  logic [WIDTH-1:0]    r_led;
  logic [WIDTH-1:0]    w_led_next;
  logic                r_bounce_dn;
  logic                w_bounce_dn_next;
  logic                r_step_pulse;

  logic                w_db_diff;
  logic                w_db_accept;
  logic                w_press;
  logic                w_step_wrap;
  logic                w_step;
  logic [WIDTH-1:0]    w_toggle_seed;

  // Alternating seed for TOGGLE: even bit positions lit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle_seed
    assign w_toggle_seed[gi] = ((gi % 2) == 0);
  end

  // Two-flop synchronizer for the asynchronous button pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= push_button;
      r_s2 <= r_s1;
    end
  end

  // The level is accepted on the DB_CYCLES-th consecutive differing edge.
  assign w_db_diff   = (r_s2 != r_db_level);
  assign w_db_accept = w_db_diff && (r_db_cnt == c_DB_LAST);
  assign w_press     = w_db_accept && r_s2;

  // Debounce counter and debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
    end else if (!w_db_diff) begin
      r_db_cnt   <= '0;
    end else if (w_db_accept) begin
      r_db_level <= r_s2;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt   <= r_db_cnt + c_DB_W'(1);
    end
  end

  // A press suppresses the step so the freshly loaded seed is held.
  assign w_step_wrap = (r_step_cnt == c_STEP_LAST);
  assign w_step      = w_step_wrap && !w_press;

  // Step timer: wraps every STEP_CYCLES edges, restarted by a mode change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_cnt <= '0;
    end else if (w_press || w_step_wrap) begin
      r_step_cnt <= '0;
    end else begin
      r_step_cnt <= r_step_cnt + c_STEP_W'(1);
    end
  end

  // Mode/pattern state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= ST_CHASE;
      r_led        <= c_ONE;
      r_bounce_dn  <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_mode       <= w_mode_next;
      r_led        <= w_led_next;
      r_bounce_dn  <= w_bounce_dn_next;
      r_step_pulse <= w_step;
    end
  end

  // Next mode, seed load on press, per-mode pattern advance on step.
  always_comb begin
    w_mode_next      = r_mode;
    w_led_next       = r_led;
    w_bounce_dn_next = r_bounce_dn;
    if (w_press) begin
      w_bounce_dn_next = 1'b0;
      case (r_mode)
        ST_CHASE: begin
          w_mode_next = ST_BOUNCE;
          w_led_next  = c_ONE;
        end
        ST_BOUNCE: begin
          w_mode_next = ST_TOGGLE;
          w_led_next  = w_toggle_seed;
        end
        ST_TOGGLE: begin
          w_mode_next = ST_COUNT;
          w_led_next  = '0;
        end
        ST_COUNT: begin
          w_mode_next = ST_CHASE;
          w_led_next  = c_ONE;
        end
      endcase
    end else if (w_step) begin
      case (r_mode)
        ST_CHASE: begin
          if (dir) w_led_next = {r_led[0], r_led[WIDTH-1:1]};
          else     w_led_next = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
        end
        ST_BOUNCE: begin
          // Turn around at either end without dwelling on the end bit.
          if (!r_bounce_dn) begin
            if (r_led[WIDTH-1]) begin
              w_led_next       = r_led >> 1;
              w_bounce_dn_next = 1'b1;
            end else begin
              w_led_next = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_led_next       = r_led << 1;
              w_bounce_dn_next = 1'b0;
            end else begin
              w_led_next = r_led >> 1;
            end
          end
        end
        ST_TOGGLE: begin
          w_led_next = ~r_led;
        end
        ST_COUNT: begin
          if (dir) w_led_next = r_led - c_ONE;
          else     w_led_next = r_led + c_ONE;
        end
      endcase
    end
  end

  assign led_out    = r_led;
  assign mode_out   = r_mode;
  assign step_pulse = r_step_pulse;

endmodule
`default_nettype wire
